// File: rtl/lsu_stage.sv
// lsu_stage: memory-access stage between EX/MEM and MEM/WB.
// Loads and stores use a request/grant/read-valid data bus. While an access
// is in flight the stage holds the upstream pipeline through stall_out.
// The stage also steers byte lanes, sign/zero-extends loads and aborts a bus
// access that takes too long.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses skip the bus and raise
//               misaligned_out with write-back suppressed.
//   undefined : misaligned_out stays 0. A half access uses only a[1] and a
//               word access forces a=0, so the access proceeds as aligned.
module lsu_stage #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic              load_in,
    input  logic              store_enable_in,
    input  logic              is_unsigned_in,
    input  logic [1:0]        mem_size_in,
    input  logic [31:0]       alu_result_in,
    input  logic [31:0]       write_data_in,
    input  logic [31:0]       pc_plus_4_in,
    input  logic [4:0]        rd_in,
    output logic              stall_out,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata,
    output logic              wb_valid,
    output logic              reg_write_out,
    output logic              mem_to_reg_out,
    output logic [31:0]       alu_result_out,
    output logic [31:0]       mem_data_out,
    output logic [31:0]       pc_plus_4_out,
    output logic [4:0]        rd_out,
    output logic              misaligned_out,
    output logic              bus_err_out
);

    // The counter must hold values up to TIMEOUT-1 before the abort fires.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Decode of the instruction currently in the EX/MEM slot.
    logic        mem_op;
    logic        store_op;
    logic [1:0]  a_raw;
    logic [1:0]  a_eff;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic        misalign_calc;
    logic        trap_now;

    // Operands latched when the access is accepted. The pipeline upstream is
    // frozen during the access, but holding a private copy keeps the bus
    // stable even if upstream misbehaves.
    logic        load_q;
    logic        store_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  a_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        rw_q;
    logic        m2r_q;
    logic [31:0] alu_q;
    logic [31:0] pc_q;
    logic [4:0]  rd_q;

    logic [CNT_W-1:0] cnt_q;
    logic             timeout_hit;
    logic             complete_ok;
    logic             abort;

    // Shift the addressed byte/half down to bit 0, then extend it to 32 bits.
    function automatic logic [31:0] format_load(
        input logic [31:0] rdata,
        input logic [1:0]  a,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [31:0] sh;
        sh = rdata >> {a, 3'b000};
        case (size)
            2'b00:   format_load = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   format_load = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: format_load = sh;
        endcase
    endfunction

    // Lane steering and alignment check for the incoming instruction.
    always_comb begin
        mem_op        = valid_in & (load_in | store_enable_in);
        store_op      = store_enable_in & ~load_in;
        a_raw         = alu_result_in[1:0];
        a_eff         = 2'b00;
        be_calc       = 4'b1111;
        wdata_calc    = write_data_in;
        misalign_calc = 1'b0;
        case (mem_size_in)
            2'b00: begin
                a_eff      = a_raw;
                be_calc    = 4'b0001 << a_raw;
                wdata_calc = {4{write_data_in[7:0]}};
            end
            2'b01: begin
                a_eff      = {a_raw[1], 1'b0};
                be_calc    = 4'b0011 << {a_raw[1], 1'b0};
                wdata_calc = {2{write_data_in[15:0]}};
            end
            default: begin
                a_eff      = 2'b00;
                be_calc    = 4'b1111;
                wdata_calc = write_data_in;
            end
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        if ((mem_size_in == 2'b01 && a_raw[0]) ||
            (mem_size_in[1] && a_raw != 2'b00)) begin
            misalign_calc = 1'b1;
        end
`endif
        trap_now = mem_op & misalign_calc;
    end

    // Completion and abort conditions of an in-flight bus access.
    always_comb begin
        timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
        complete_ok = 1'b0;
        if (state_q == S_REQ && bus_gnt && (store_q || bus_rvalid)) begin
            complete_ok = 1'b1;
        end
        if (state_q == S_WAIT && bus_rvalid) begin
            complete_ok = 1'b1;
        end
        abort = (state_q == S_REQ || state_q == S_WAIT) && timeout_hit && !complete_ok;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    state_d = trap_now ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (complete_ok || abort) begin
                    state_d = S_DONE;
                end else if (bus_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (complete_ok || abort) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: pipeline stall and the bus request signals. Bus fields are
    // forced to zero outside REQ so they read as zero during reset and idle.
    always_comb begin
        stall_out = 1'b0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_be    = 4'b0000;
        bus_wdata = 32'h0;
        case (state_q)
            S_IDLE: stall_out = rst & mem_op;
            S_REQ: begin
                stall_out = 1'b1;
                bus_req   = 1'b1;
                bus_we    = store_q;
                bus_addr  = ADDR_W'(addr_q);
                bus_be    = be_q;
                bus_wdata = wdata_q;
            end
            S_WAIT:  stall_out = 1'b1;
            default: stall_out = 1'b0;
        endcase
    end

    // Capture the operands of a memory instruction when it is accepted.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && mem_op) begin
            load_q  <= load_in;
            store_q <= store_op;
            uns_q   <= is_unsigned_in;
            size_q  <= mem_size_in;
            a_q     <= a_eff;
            addr_q  <= {alu_result_in[31:2], 2'b00};
            be_q    <= be_calc;
            wdata_q <= wdata_calc;
            rw_q    <= reg_write_in;
            m2r_q   <= mem_to_reg_in;
            alu_q   <= alu_result_in;
            pc_q    <= pc_plus_4_in;
            rd_q    <= rd_in;
        end
    end

    // Bus timeout counter: cleared while idle, counts every REQ/WAIT cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_q == S_REQ || state_q == S_WAIT) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    // MEM/WB output register. The valid bit and the exception flags default to
    // 0 every cycle, so they are high only for the single update that carries
    // a result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid       <= 1'b0;
            reg_write_out  <= 1'b0;
            mem_to_reg_out <= 1'b0;
            alu_result_out <= 32'h0;
            mem_data_out   <= 32'h0;
            pc_plus_4_out  <= 32'h0;
            rd_out         <= 5'h0;
            misaligned_out <= 1'b0;
            bus_err_out    <= 1'b0;
        end else begin
            wb_valid       <= 1'b0;
            misaligned_out <= 1'b0;
            bus_err_out    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!mem_op) begin
                        wb_valid       <= valid_in;
                        reg_write_out  <= reg_write_in;
                        mem_to_reg_out <= mem_to_reg_in;
                        alu_result_out <= alu_result_in;
                        mem_data_out   <= 32'h0;
                        pc_plus_4_out  <= pc_plus_4_in;
                        rd_out         <= rd_in;
                    end else if (trap_now) begin
                        wb_valid       <= 1'b1;
                        reg_write_out  <= 1'b0;
                        mem_to_reg_out <= mem_to_reg_in;
                        alu_result_out <= alu_result_in;
                        mem_data_out   <= 32'h0;
                        pc_plus_4_out  <= pc_plus_4_in;
                        rd_out         <= rd_in;
                        misaligned_out <= 1'b1;
                    end
                end
                S_REQ, S_WAIT: begin
                    if (complete_ok) begin
                        wb_valid       <= 1'b1;
                        reg_write_out  <= rw_q;
                        mem_to_reg_out <= m2r_q;
                        alu_result_out <= alu_q;
                        mem_data_out   <= load_q ? format_load(bus_rdata, a_q, size_q, uns_q) : 32'h0;
                        pc_plus_4_out  <= pc_q;
                        rd_out         <= rd_q;
                    end else if (abort) begin
                        wb_valid       <= 1'b1;
                        reg_write_out  <= 1'b0;
                        mem_to_reg_out <= m2r_q;
                        alu_result_out <= alu_q;
                        mem_data_out   <= 32'h0;
                        pc_plus_4_out  <= pc_q;
                        rd_out         <= rd_q;
                        bus_err_out    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// Scoreboard bench for lsu_stage. The stimulus thread pushes the expected
// MEM/WB record for each instruction. A negedge monitor pops a record and
// compares it whenever wb_valid is high. A second instance with TIMEOUT=4
// covers the bus-abort path.
module tb_lsu_stage;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        mis;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0, valid2 = 1'b0;
    logic        reg_write_in = 1'b0, mem_to_reg_in = 1'b0, load_in = 1'b0;
    logic        store_enable_in = 1'b0, is_unsigned_in = 1'b0;
    logic [1:0]  mem_size_in = 2'b00;
    logic [31:0] alu_result_in = 32'h0, write_data_in = 32'h0, pc_plus_4_in = 32'h0;
    logic [4:0]  rd_in = 5'h0;
    logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        gnt2 = 1'b0, rvalid2 = 1'b0;
    logic [31:0] rdata2 = 32'h0;

    logic        stall_out, bus_req, bus_we, wb_valid, reg_write_out, mem_to_reg_out;
    logic        misaligned_out, bus_err_out;
    logic [31:0] bus_addr, bus_wdata, alu_result_out, mem_data_out, pc_plus_4_out;
    logic [3:0]  bus_be;
    logic [4:0]  rd_out;

    logic        stall_t, req_t, we_t, wbv_t, rw_t, m2r_t, mis_t, err_t;
    logic [31:0] addr_t, wdata_t, alu_t, mem_t, pc_t;
    logic [3:0]  be_t;
    logic [4:0]  rd_t;

    int checks = 0;
    int errors = 0;
    exp_t q_main[$];
    exp_t q_to[$];

    always #5 clk = ~clk;

    lsu_stage #(.ADDR_W(32), .TIMEOUT(255)) u_dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in), .load_in(load_in),
        .store_enable_in(store_enable_in), .is_unsigned_in(is_unsigned_in),
        .mem_size_in(mem_size_in), .alu_result_in(alu_result_in),
        .write_data_in(write_data_in), .pc_plus_4_in(pc_plus_4_in), .rd_in(rd_in),
        .stall_out(stall_out), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .wb_valid(wb_valid), .reg_write_out(reg_write_out),
        .mem_to_reg_out(mem_to_reg_out), .alu_result_out(alu_result_out),
        .mem_data_out(mem_data_out), .pc_plus_4_out(pc_plus_4_out), .rd_out(rd_out),
        .misaligned_out(misaligned_out), .bus_err_out(bus_err_out)
    );

    lsu_stage #(.ADDR_W(32), .TIMEOUT(4)) u_dut_to (
        .clk(clk), .rst(rst), .valid_in(valid2),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in), .load_in(load_in),
        .store_enable_in(store_enable_in), .is_unsigned_in(is_unsigned_in),
        .mem_size_in(mem_size_in), .alu_result_in(alu_result_in),
        .write_data_in(write_data_in), .pc_plus_4_in(pc_plus_4_in), .rd_in(rd_in),
        .stall_out(stall_t), .bus_req(req_t), .bus_we(we_t), .bus_addr(addr_t),
        .bus_be(be_t), .bus_wdata(wdata_t), .bus_gnt(gnt2), .bus_rvalid(rvalid2),
        .bus_rdata(rdata2), .wb_valid(wbv_t), .reg_write_out(rw_t),
        .mem_to_reg_out(m2r_t), .alu_result_out(alu_t),
        .mem_data_out(mem_t), .pc_plus_4_out(pc_t), .rd_out(rd_t),
        .misaligned_out(mis_t), .bus_err_out(err_t)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] alu, mem, pc, input logic [4:0] rd,
                                input logic rw, m2r, mis, err);
        exp_t e;
        e.alu = alu; e.mem = mem; e.pc = pc; e.rd = rd;
        e.rw = rw; e.m2r = m2r; e.mis = mis; e.err = err;
        return e;
    endfunction

    // Monitor: compare every presented MEM/WB record with the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (wb_valid) begin
            if (q_main.size() == 0) begin
                chk("unexpected_wb_valid", 1, 0);
            end else begin
                e = q_main.pop_front();
                chk("wb_alu", alu_result_out, e.alu);
                chk("wb_mem_data", mem_data_out, e.mem);
                chk("wb_pc4", pc_plus_4_out, e.pc);
                chk("wb_rd", rd_out, e.rd);
                chk("wb_reg_write", reg_write_out, e.rw);
                chk("wb_mem_to_reg", mem_to_reg_out, e.m2r);
                chk("wb_misaligned", misaligned_out, e.mis);
                chk("wb_bus_err", bus_err_out, e.err);
            end
        end
        if (wbv_t) begin
            if (q_to.size() == 0) begin
                chk("unexpected_wb_valid_to", 1, 0);
            end else begin
                e = q_to.pop_front();
                chk("to_alu", alu_t, e.alu);
                chk("to_mem_data", mem_t, e.mem);
                chk("to_rd", rd_t, e.rd);
                chk("to_reg_write", rw_t, e.rw);
                chk("to_bus_err", err_t, e.err);
                chk("to_misaligned", mis_t, e.mis);
            end
        end
    end

    task automatic drive(input logic ld, st, uns, input logic [1:0] sz,
                         input logic [31:0] alu, wd, pc, input logic [4:0] rd,
                         input logic rw, m2r);
        valid_in = 1'b1; load_in = ld; store_enable_in = st; is_unsigned_in = uns;
        mem_size_in = sz; alu_result_in = alu; write_data_in = wd; pc_plus_4_in = pc;
        rd_in = rd; reg_write_in = rw; mem_to_reg_in = m2r;
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0; valid2 = 1'b0; load_in = 1'b0; store_enable_in = 1'b0;
    endtask

    // Runs one memory access on the main instance, starting in its IDLE cycle
    // (called at posedge+1 with the instruction already driven). Cycle 0 is
    // the IDLE cycle; grant/read-valid are raised on the given cycle numbers.
    task automatic mem_txn(input string nm, input int gnt_at, input int rv_at,
                           input logic [31:0] rdata, input int exp_stalls,
                           input logic exp_req, input logic [3:0] exp_be,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                           input logic exp_we);
        int  stalls = 0;
        bit  done = 0;
        bit  seen_req = 0;
        for (int c = 0; c < 300; c++) begin
            #2;
            if (!stall_out) begin
                done = 1;
                break;
            end
            stalls++;
            if (bus_req && !seen_req) begin
                seen_req = 1;
                chk({nm, "_be"}, bus_be, exp_be);
                chk({nm, "_addr"}, bus_addr, exp_addr);
                chk({nm, "_we"}, bus_we, exp_we);
                if (exp_we) chk({nm, "_wdata"}, bus_wdata, exp_wdata);
            end
            bus_gnt    = (c == gnt_at);
            bus_rvalid = (c == rv_at);
            bus_rdata  = (c == rv_at) ? rdata : 32'h0;
            @(posedge clk); #1;
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        chk({nm, "_completed"}, done, 1);
        chk({nm, "_stall_cycles"}, stalls, exp_stalls);
        chk({nm, "_bus_req_seen"}, seen_req, exp_req);
        chk({nm, "_done_no_req"}, bus_req, 0);
        idle_inputs();
        @(posedge clk); #1;
    endtask

    initial begin
        int  stalls_t;
        bit  done_t;

        // Reset state, with a live load presented to show stall is held low.
        drive(1, 0, 0, 2'b10, 32'h104, 0, 0, 1, 1, 1);
        repeat (2) @(posedge clk);
        #3;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_mem_data", mem_data_out, 0);
        chk("rst_flags", {misaligned_out, bus_err_out}, 0);
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Two back-to-back non-memory instructions: 1-cycle latency, no stall.
        drive(0, 0, 0, 2'b10, 32'h1111_2222, 32'h0, 32'h40, 5'd3, 1, 0);
        q_main.push_back(mk(32'h1111_2222, 0, 32'h40, 5'd3, 1, 0, 0, 0));
        #2; chk("alu_stall", stall_out, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 2'b00, 32'hA5A5_0001, 32'h0, 32'h44, 5'd9, 0, 0);
        q_main.push_back(mk(32'hA5A5_0001, 0, 32'h44, 5'd9, 0, 0, 0, 0));
        #2; chk("alu2_stall", stall_out, 0);
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;

        // LB at 0x103, grant and read data in the first REQ cycle.
        drive(1, 0, 0, 2'b00, 32'h103, 0, 32'h104, 5'd5, 1, 1);
        q_main.push_back(mk(32'h103, 32'hFFFF_FF80, 32'h104, 5'd5, 1, 1, 0, 0));
        mem_txn("lb", 1, 1, 32'h80FF_FF7F, 2, 1, 4'b1000, 32'h100, 0, 0);

        // SH 0x1234 at 0x202, grant on the third REQ cycle.
        drive(0, 1, 0, 2'b01, 32'h202, 32'h0000_1234, 32'h108, 5'd0, 0, 0);
        q_main.push_back(mk(32'h202, 0, 32'h108, 5'd0, 0, 0, 0, 0));
        mem_txn("sh", 3, -1, 0, 4, 1, 4'b1100, 32'h200, 32'h1234_1234, 1);

        // LHU at 0x002, grant then read data four cycles later.
        drive(1, 0, 1, 2'b01, 32'h002, 0, 32'h10C, 5'd6, 1, 1);
        q_main.push_back(mk(32'h002, 32'h0000_BEEF, 32'h10C, 5'd6, 1, 1, 0, 0));
        mem_txn("lhu", 1, 5, 32'hBEEF_0000, 6, 1, 4'b1100, 32'h0, 0, 0);

        // LH signed at 0x002.
        drive(1, 0, 0, 2'b01, 32'h002, 0, 32'h110, 5'd7, 1, 1);
        q_main.push_back(mk(32'h002, 32'hFFFF_8001, 32'h110, 5'd7, 1, 1, 0, 0));
        mem_txn("lh", 1, 1, 32'h8001_0000, 2, 1, 4'b1100, 32'h0, 0, 0);

        // LBU at 0x101, read data one cycle after grant.
        drive(1, 0, 1, 2'b00, 32'h101, 0, 32'h114, 5'd8, 1, 1);
        q_main.push_back(mk(32'h101, 32'h0000_009A, 32'h114, 5'd8, 1, 1, 0, 0));
        mem_txn("lbu", 1, 2, 32'h0000_9A00, 3, 1, 4'b0010, 32'h100, 0, 0);

        // SB 0xAB at 0x001.
        drive(0, 1, 0, 2'b00, 32'h001, 32'h1234_56AB, 32'h118, 5'd0, 0, 0);
        q_main.push_back(mk(32'h001, 0, 32'h118, 5'd0, 0, 0, 0, 0));
        mem_txn("sb", 1, -1, 0, 2, 1, 4'b0010, 32'h0, 32'hABAB_ABAB, 1);

        // SW at 0x300 with reg_write_in=1 passed through unchanged.
        drive(0, 1, 0, 2'b10, 32'h300, 32'hDEAD_BEEF, 32'h11C, 5'd4, 1, 0);
        q_main.push_back(mk(32'h300, 0, 32'h11C, 5'd4, 1, 0, 0, 0));
        mem_txn("sw", 1, -1, 0, 2, 1, 4'b1111, 32'h300, 32'hDEAD_BEEF, 1);

        // LW at 0x101: trapped with the macro, otherwise forced word-aligned.
        drive(1, 0, 0, 2'b10, 32'h101, 0, 32'h120, 5'd10, 1, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        q_main.push_back(mk(32'h101, 0, 32'h120, 5'd10, 0, 1, 1, 0));
        mem_txn("lw_mis", 1, 1, 32'h1122_3344, 1, 0, 4'b0000, 32'h0, 0, 0);
`else
        q_main.push_back(mk(32'h101, 32'h1122_3344, 32'h120, 5'd10, 1, 1, 0, 0));
        mem_txn("lw_mis", 1, 1, 32'h1122_3344, 2, 1, 4'b1111, 32'h100, 0, 0);
`endif

        // LW on the TIMEOUT=4 instance with no grant: abort after 4 REQ cycles.
        drive(1, 0, 0, 2'b10, 32'h400, 0, 32'h124, 5'd11, 1, 1);
        valid_in = 1'b0;
        valid2   = 1'b1;
        q_to.push_back(mk(32'h400, 0, 32'h124, 5'd11, 0, 1, 0, 1));
        stalls_t = 0;
        done_t   = 0;
        for (int c = 0; c < 50; c++) begin
            #2;
            if (!stall_t) begin
                done_t = 1;
                break;
            end
            stalls_t++;
            if (c == 1) chk("to_bus_req", req_t, 1);
            @(posedge clk); #1;
        end
        chk("to_completed", done_t, 1);
        chk("to_stall_cycles", stalls_t, 5);
        idle_inputs();
        @(posedge clk); #1;

        // Reset while REQ is active: request and stall drop immediately.
        drive(1, 0, 0, 2'b10, 32'h500, 0, 32'h128, 5'd12, 1, 1);
        @(posedge clk); #1;
        #2;
        chk("rstmid_req_before", bus_req, 1);
        rst = 1'b0;
        #1;
        chk("rstmid_req", bus_req, 0);
        chk("rstmid_stall", stall_out, 0);
        chk("rstmid_wb_valid", wb_valid, 0);
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        chk("rstmid_idle_req", bus_req, 0);
        chk("rstmid_idle_stall", stall_out, 0);
        @(posedge clk); #1;

        // Back in IDLE: a non-memory instruction passes straight through.
        drive(0, 0, 0, 2'b10, 32'h0BAD_F00D, 32'h0, 32'h200, 5'd13, 1, 0);
        q_main.push_back(mk(32'h0BAD_F00D, 0, 32'h200, 5'd13, 1, 0, 0, 0));
        #2; chk("post_rst_stall", stall_out, 0);
        @(posedge clk); #1;
        idle_inputs();

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_main_empty", q_main.size(), 0);
        chk("scoreboard_to_empty", q_to.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
